// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle logic/arith ops with a registered result, plus iterative unsigned MULTU/DIVU into HI/LO.
// Latency 1 cycle for single-cycle ops, WIDTH cycles for mul/div; start is ignored (not queued) while busy.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] select,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [SEL_W-1:0] OP_AND   = SEL_W'(4'b0000);
  localparam logic [SEL_W-1:0] OP_OR    = SEL_W'(4'b0001);
  localparam logic [SEL_W-1:0] OP_ADD   = SEL_W'(4'b0010);
  localparam logic [SEL_W-1:0] OP_SLTU  = SEL_W'(4'b0011);
  localparam logic [SEL_W-1:0] OP_SUB   = SEL_W'(4'b0110);
  localparam logic [SEL_W-1:0] OP_SLT   = SEL_W'(4'b0111);
  localparam logic [SEL_W-1:0] OP_MULTU = SEL_W'(4'b1000);
  localparam logic [SEL_W-1:0] OP_DIVU  = SEL_W'(4'b1001);
  localparam logic [SEL_W-1:0] OP_MFHI  = SEL_W'(4'b1010);
  localparam logic [SEL_W-1:0] OP_MFLO  = SEL_W'(4'b1011);
  localparam logic [SEL_W-1:0] OP_NOR   = SEL_W'(4'b1100);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_hi;   // MUL: partial product high half; DIV: partial remainder
  logic [WIDTH-1:0] acc_lo;   // MUL: multiplier/product low half; DIV: dividend/quotient
  logic [WIDTH-1:0] opnd;     // MUL: multiplicand; DIV: divisor
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic             last;

  always_comb begin
    res = '0;
    case (select)
      OP_AND:  res = first & second;
      OP_OR:   res = first | second;
      OP_ADD:  res = first + second;
      OP_SUB:  res = first - second;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(first) < $signed(second))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (first < second)};
      OP_NOR:  res = ~(first | second);
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // One shift-add or one restoring-subtract step per cycle. When the top remainder
  // bit is set the shifted value already exceeds any W-bit divisor, so W-bit
  // modular subtraction still yields the exact remainder.
  always_comb begin
    it_hi   = acc_hi;
    it_lo   = acc_lo;
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    div_ge  = acc_hi[WIDTH-1] || (div_sh >= opnd);
    if (state == MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      it_hi = div_ge ? (div_sh - opnd) : div_sh;
      it_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out         <= '0;
      zero        <= 1'b1;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (select == OP_MULTU || select == OP_DIVU) begin
              state  <= (select == OP_MULTU) ? MUL : DIV;
              busy   <= 1'b1;
              acc_hi <= '0;
              acc_lo <= (select == OP_MULTU) ? second : first;
              opnd   <= (select == OP_MULTU) ? first : second;
              cnt    <= '0;
              dz     <= (second == '0);
            end else begin
              out  <= res;
              zero <= (res == '0);
              done <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          acc_hi <= it_hi;
          acc_lo <= it_lo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            hi          <= it_hi;
            lo          <= it_lo;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= (state == DIV) && dz;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
// Latency: not applicable (bench); drives ops and samples 1ns after each rising edge.
// Backpressure: waits on done while the DUT is busy.
module tb_alu_muldiv;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  select;
    logic [31:0] first, second, out, hi, lo;
    logic        zero, busy, done, div_by_zero;

    logic        start8;
    logic [3:0]  select8;
    logic [7:0]  first8, second8, out8, hi8, lo8;
    logic        zero8, busy8, done8, dbz8;

    int checks = 0;
    int failures = 0;
    int n;
    int nd;

    alu_muldiv #(.WIDTH(32), .SEL_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .select(select),
        .first(first), .second(second), .out(out), .zero(zero),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    alu_muldiv #(.WIDTH(8), .SEL_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .select(select8),
        .first(first8), .second(second8), .out(out8), .zero(zero8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        select = s;
        first  = a;
        second = b;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, input int start_cnt);
        cyc = start_cnt;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; select = '0; first = '0; second = '0;
        start8 = 1'b0; select8 = '0; first8 = '0; second8 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL rst_out observed=%0h", out); end
        checks++; if (zero !== 1'b1) begin failures++; $error("FAIL rst_zero observed=%0h", zero); end
        checks++; if (hi !== 32'h0) begin failures++; $error("FAIL rst_hi observed=%0h", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $error("FAIL rst_lo observed=%0h", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $error("FAIL rst_busy observed=%0h", busy); end
        checks++; if (done !== 1'b0) begin failures++; $error("FAIL rst_done observed=%0h", done); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $error("FAIL rst_dbz observed=%0h", div_by_zero); end
        checks++; if (hi8 !== 8'h0) begin failures++; $error("FAIL rst_hi8 observed=%0h", hi8); end
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        start = 1'b0;
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL add_out observed=%0h", out); end
        checks++; if (zero !== 1'b1) begin failures++; $error("FAIL add_zero observed=%0h", zero); end
        checks++; if (done !== 1'b1) begin failures++; $error("FAIL add_done observed=%0h", done); end
        checks++; if (busy !== 1'b0) begin failures++; $error("FAIL add_busy observed=%0h", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $error("FAIL add_done_pulse observed=%0h", done); end

        issue(4'b0111, 32'hFFFF_FFFE, 32'h0000_0003);
        checks++; if (out !== 32'h1) begin failures++; $error("FAIL slt_out observed=%0h", out); end
        checks++; if (zero !== 1'b0) begin failures++; $error("FAIL slt_zero observed=%0h", zero); end
        issue(4'b0011, 32'hFFFF_FFFE, 32'h0000_0003);
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL sltu_out observed=%0h", out); end
        checks++; if (done !== 1'b1) begin failures++; $error("FAIL sltu_done observed=%0h", done); end
        issue(4'b0110, 32'h5, 32'h5);
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL sub_out observed=%0h", out); end
        checks++; if (zero !== 1'b1) begin failures++; $error("FAIL sub_zero observed=%0h", zero); end
        checks++; if (done !== 1'b1) begin failures++; $error("FAIL sub_done observed=%0h", done); end
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        checks++; if (out !== 32'h0000_F000) begin failures++; $error("FAIL and_out observed=%0h", out); end
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
        checks++; if (out !== 32'h0000_FFF0) begin failures++; $error("FAIL or_out observed=%0h", out); end
        issue(4'b1100, 32'h0000_F0F0, 32'h0000_FF00);
        checks++; if (out !== 32'hFFFF_000F) begin failures++; $error("FAIL nor_out observed=%0h", out); end
        issue(4'b0110, 32'h3, 32'h5);
        checks++; if (out !== 32'hFFFF_FFFE) begin failures++; $error("FAIL sub_wrap observed=%0h", out); end
        issue(4'b0100, 32'h1234, 32'h5678);
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL undef_out observed=%0h", out); end
        checks++; if (done !== 1'b1) begin failures++; $error("FAIL undef_done observed=%0h", done); end
        start = 1'b0;
        @(posedge clk); #1;

        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $error("FAIL mul_busy observed=%0h", busy); end
        checks++; if (done !== 1'b0) begin failures++; $error("FAIL mul_nodone observed=%0h", done); end
        wait_done(n, 0);
        checks++; if (n != 32) begin failures++; $error("FAIL mul_latency observed=%0d", n); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $error("FAIL mul_hi observed=%0h", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $error("FAIL mul_lo observed=%0h", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $error("FAIL mul_busy_end observed=%0h", busy); end
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL mul_out_held observed=%0h", out); end
        issue(4'b1010, 32'h0, 32'h0);
        checks++; if (out !== 32'hFFFF_FFFE) begin failures++; $error("FAIL mfhi_out observed=%0h", out); end
        issue(4'b1011, 32'h0, 32'h0);
        checks++; if (out !== 32'h0000_0001) begin failures++; $error("FAIL mflo_out observed=%0h", out); end
        start = 1'b0;
        @(posedge clk); #1;

        issue(4'b1001, 32'd100, 32'd7);
        start = 1'b0;
        wait_done(n, 0);
        checks++; if (n != 32) begin failures++; $error("FAIL div_latency observed=%0d", n); end
        checks++; if (lo !== 32'd14) begin failures++; $error("FAIL div_lo observed=%0h", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $error("FAIL div_hi observed=%0h", hi); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $error("FAIL div_dbz observed=%0h", div_by_zero); end
        issue(4'b1001, 32'h1234, 32'h0);
        start = 1'b0;
        wait_done(n, 0);
        checks++; if (n != 32) begin failures++; $error("FAIL dz_latency observed=%0d", n); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $error("FAIL dz_lo observed=%0h", lo); end
        checks++; if (hi !== 32'h0000_1234) begin failures++; $error("FAIL dz_hi observed=%0h", hi); end
        checks++; if (div_by_zero !== 1'b1) begin failures++; $error("FAIL dz_flag observed=%0h", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (div_by_zero !== 1'b0) begin failures++; $error("FAIL dz_flag_pulse observed=%0h", div_by_zero); end

        issue(4'b1000, 32'd3, 32'd5);
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin failures++; $error("FAIL mid_busy observed=%0h", busy); end
        checks++; if (hi !== 32'h0000_1234) begin failures++; $error("FAIL mid_hi_hold observed=%0h", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $error("FAIL mid_lo_hold observed=%0h", lo); end
        start = 1'b1; select = 4'b0000; first = 32'hFFFF_FFFF; second = 32'h0;
        wait_done(n, 4);
        checks++; if (n != 32) begin failures++; $error("FAIL ign_latency observed=%0d", n); end
        checks++; if (out !== 32'h1) begin failures++; $error("FAIL ign_out observed=%0h", out); end
        checks++; if (hi !== 32'h0) begin failures++; $error("FAIL ign_hi observed=%0h", hi); end
        checks++; if (lo !== 32'd15) begin failures++; $error("FAIL ign_lo observed=%0h", lo); end
        @(posedge clk); #1;
        checks++; if (out !== 32'h0) begin failures++; $error("FAIL next_accept_out observed=%0h", out); end
        checks++; if (zero !== 1'b1) begin failures++; $error("FAIL next_accept_zero observed=%0h", zero); end
        checks++; if (done !== 1'b1) begin failures++; $error("FAIL next_accept_done observed=%0h", done); end
        start = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $error("FAIL next_done_clear observed=%0h", done); end

        issue(4'b1001, 32'd100, 32'd7);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $error("FAIL abort_busy observed=%0h", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $error("FAIL abort_hi observed=%0h", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $error("FAIL abort_lo observed=%0h", lo); end
        checks++; if (done !== 1'b0) begin failures++; $error("FAIL abort_done observed=%0h", done); end
        checks++; if (zero !== 1'b1) begin failures++; $error("FAIL abort_zero observed=%0h", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        checks++; if (nd != 0) begin failures++; $error("FAIL abort_no_done observed=%0d", nd); end

        @(negedge clk);
        start8 = 1'b1; select8 = 4'b1000; first8 = 8'hFF; second8 = 8'hFF;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++; if (busy8 !== 1'b1) begin failures++; $error("FAIL mul8_busy observed=%0h", busy8); end
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n != 8) begin failures++; $error("FAIL mul8_latency observed=%0d", n); end
        checks++; if (hi8 !== 8'hFE) begin failures++; $error("FAIL mul8_hi observed=%0h", hi8); end
        checks++; if (lo8 !== 8'h01) begin failures++; $error("FAIL mul8_lo observed=%0h", lo8); end
        @(negedge clk);
        start8 = 1'b1; select8 = 4'b1001; first8 = 8'd200; second8 = 8'd13;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n != 8) begin failures++; $error("FAIL div8_latency observed=%0d", n); end
        checks++; if (lo8 !== 8'd15) begin failures++; $error("FAIL div8_lo observed=%0h", lo8); end
        checks++; if (hi8 !== 8'd5) begin failures++; $error("FAIL div8_hi observed=%0h", hi8); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
